// File: rtl/inst_fetch_stage.sv
// IF stage: PC register, async instruction-ROM address, IF/ID register; 1-cycle fetch latency.
// stall_in freezes PC and IF/ID; taken redirects squash IF/ID (1 bubble) unless IF_DELAY_SLOT_EN keeps the delay slot.
// Optional feature macro: IF_DELAY_SLOT_EN.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [15:0] branch_offset_in,
    input  logic        jump_in,
    input  logic [25:0] jump_index_in,
    input  logic        jr_in,
    input  logic [31:0] jr_addr_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic [31:0] ins_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out,
    output logic        align_err_out
);

    logic [31:0] r_pc;
    logic [31:0] r_ins;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc4_id;
    logic        r_valid;
    logic        r_align_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_target;
    logic        w_jr_acc;
    logic        w_jump_acc;
    logic        w_br_acc;
    logic        w_redirect;
    logic        w_squash;
    logic        w_jr_misaligned;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_br_target     = r_pc4_id + {{14{branch_offset_in[15]}}, branch_offset_in, 2'b00};
    assign w_jump_target   = {r_pc4_id[31:28], jump_index_in, 2'b00};
    assign w_jr_target     = {jr_addr_in[31:2], 2'b00};
    assign w_jr_misaligned = (jr_addr_in[1:0] != 2'b00);

    // Redirects come from the instruction held in IF/ID, so a bubble cannot redirect.
    assign w_jr_acc   = r_valid & jr_in;
    assign w_jump_acc = r_valid & jump_in;
    assign w_br_acc   = r_valid & branch_taken_in;
    assign w_redirect = w_jr_acc | w_jump_acc | w_br_acc;

    always_comb begin
        w_target = w_pc_plus4;
        if (w_jr_acc) begin
            w_target = w_jr_target;
        end else if (w_jump_acc) begin
            w_target = w_jump_target;
        end else if (w_br_acc) begin
            w_target = w_br_target;
        end
    end

`ifdef IF_DELAY_SLOT_EN
    assign w_squash = 1'b0;
`else
    assign w_squash = w_redirect;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ins       <= NOP_WORD;
            r_pc_id     <= 32'd0;
            r_pc4_id    <= 32'd0;
            r_valid     <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            if (!stall_in) begin
                r_pc        <= w_target;
                r_pc_id     <= r_pc;
                r_pc4_id    <= w_pc_plus4;
                r_ins       <= w_squash ? NOP_WORD : imem_data_in;
                r_valid     <= ~w_squash;
                r_align_err <= w_jr_acc & w_jr_misaligned;
            end
        end
    end

    assign imem_addr_out = r_pc;
    assign ins_out       = r_ins;
    assign pc_out        = r_pc_id;
    assign pc_plus4_out  = r_pc4_id;
    assign valid_out     = r_valid;
    assign align_err_out = r_align_err;

endmodule
